// File: rtl/peak_dpu_pkg.sv
// Shared DPU definitions: load/store op codes, exception causes and LSU FSM states.
// Helpers classify ops for the LSU controller.
package peak_dpu_pkg;

   typedef enum logic [2:0] {
      LS_LB  = 3'd0,
      LS_LH  = 3'd1,
      LS_LW  = 3'd2,
      LS_LBU = 3'd3,
      LS_LHU = 3'd4,
      LS_SB  = 3'd5,
      LS_SH  = 3'd6,
      LS_SW  = 3'd7
   } ls_op_e;

   typedef enum logic [1:0] {
      EXC_LD_MISAL = 2'd0,
      EXC_ST_MISAL = 2'd1,
      EXC_LD_FAULT = 2'd2,
      EXC_ST_FAULT = 2'd3
   } exc_cause_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_DONE = 3'd3,
      ST_EXC  = 3'd4
   } lsu_state_e;

   function automatic logic is_store(ls_op_e op);
      return (op == LS_SB) || (op == LS_SH) || (op == LS_SW);
   endfunction

   function automatic logic misaligned(ls_op_e op, logic [1:0] a);
      logic m;
      m = 1'b0;
      case (op)
         LS_LH, LS_LHU, LS_SH: m = a[0];
         LS_LW, LS_SW:         m = |a;
         default:              m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/peak_dpu_lsu_align.sv
// Byte-lane steering for the LSU: store enables/replication and
// load lane extraction with sign or zero extension.
module peak_dpu_lsu_align
   import peak_dpu_pkg::*;
(
   input  ls_op_e      op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] st_data,
   input  logic [31:0] rd_data,
   output logic [3:0]  be,
   output logic [31:0] st_lanes,
   output logic [31:0] ld_data
);

   logic [31:0] lane;

   // addressed byte/half moved down to bit 0
   assign lane = rd_data >> {addr_lo, 3'b000};

   always_comb begin
      be       = 4'b0000;
      st_lanes = 32'd0;
      ld_data  = 32'd0;
      unique case (op)
         LS_LB, LS_LBU, LS_SB: begin
            be       = 4'b0001 << addr_lo;
            st_lanes = {4{st_data[7:0]}};
         end
         LS_LH, LS_LHU, LS_SH: begin
            be       = addr_lo[1] ? 4'b1100 : 4'b0011;
            st_lanes = {2{st_data[15:0]}};
         end
         LS_LW, LS_SW: begin
            be       = 4'b1111;
            st_lanes = st_data;
         end
      endcase
      unique case (op)
         LS_LB:   ld_data = {{24{lane[7]}}, lane[7:0]};
         LS_LBU:  ld_data = {24'd0, lane[7:0]};
         LS_LH:   ld_data = {{16{lane[15]}}, lane[15:0]};
         LS_LHU:  ld_data = {16'd0, lane[15:0]};
         default: ld_data = lane;
      endcase
   end

endmodule

// File: rtl/peak_dpu_lsu_ctrl.sv
// DPU load/store sequencer: alignment check, single outstanding bus
// transaction with timeout, load writeback and exception reporting.
module peak_dpu_lsu_ctrl
   import peak_dpu_pkg::*;
#(
   parameter int TMO_W  = 8,
   parameter bit TMO_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ls_req_vld,
   output logic        ls_req_rdy,
   input  logic [2:0]  ls_op,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   input  logic [4:0]  ls_rd,
   input  logic        lsu_flush,
   output logic        dbus_req_vld,
   input  logic        dbus_req_rdy,
   output logic [31:0] dbus_req_addr,
   output logic        dbus_req_we,
   output logic [3:0]  dbus_req_be,
   output logic [31:0] dbus_req_wdata,
   input  logic        dbus_rsp_vld,
   input  logic [31:0] dbus_rsp_rdata,
   input  logic        dbus_rsp_err,
   output logic        lsu_wb_vld,
   output logic [4:0]  lsu_wb_addr,
   output logic [31:0] lsu_wb_data,
   output logic        lsu_done,
   output logic        lsu_exc_vld,
   output logic [1:0]  lsu_exc_cause,
   output logic [31:0] lsu_exc_addr,
   output logic        lsu_busy
);

   lsu_state_e       state_q, state_d;
   ls_op_e           op_q, op_in;
   logic [31:0]      addr_q, wdata_q, rdata_q;
   logic [4:0]       rd_q;
   exc_cause_e       cause_q;
   logic             kill_q;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             tmo_hit, kill, accept;
   logic [3:0]       be;
   logic [31:0]      st_lanes, ld_data;

   assign op_in  = ls_op_e'(ls_op);
   assign accept = (state_q == ST_IDLE) && ls_req_vld && !lsu_flush;
   assign kill   = kill_q || lsu_flush;
   assign tmo_d  = tmo_q + 1'b1;
   // fires on the (2**TMO_W-1)th response-less WAIT cycle
   assign tmo_hit = TMO_EN && (&tmo_d);

   peak_dpu_lsu_align u_align (
      .op       (op_q),
      .addr_lo  (addr_q[1:0]),
      .st_data  (wdata_q),
      .rd_data  (rdata_q),
      .be       (be),
      .st_lanes (st_lanes),
      .ld_data  (ld_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= LS_LB;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rd_q    <= 5'd0;
         rdata_q <= 32'd0;
         cause_q <= EXC_LD_MISAL;
         kill_q  <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q    <= op_in;
            addr_q  <= ls_addr;
            wdata_q <= ls_wdata;
            rd_q    <= ls_rd;
            kill_q  <= 1'b0;
            cause_q <= is_store(op_in) ? EXC_ST_MISAL : EXC_LD_MISAL;
         end
         if (state_q == ST_REQ && dbus_req_rdy) begin
            tmo_q  <= '0;
            kill_q <= lsu_flush;
         end
         if (state_q == ST_WAIT) begin
            tmo_q   <= tmo_d;
            cause_q <= is_store(op_q) ? EXC_ST_FAULT : EXC_LD_FAULT;
            if (lsu_flush)
               kill_q <= 1'b1;
            if (dbus_rsp_vld)
               rdata_q <= dbus_rsp_rdata;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      ls_req_rdy   = 1'b0;
      dbus_req_vld = 1'b0;
      lsu_done     = 1'b0;
      lsu_wb_vld   = 1'b0;
      lsu_exc_vld  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            ls_req_rdy = 1'b1;
            if (accept)
               state_d = misaligned(op_in, ls_addr[1:0]) ? ST_EXC : ST_REQ;
         end
         ST_REQ: begin
            dbus_req_vld = 1'b1;
            if (dbus_req_rdy)
               state_d = ST_WAIT;
            else if (lsu_flush)
               state_d = ST_IDLE;
         end
         ST_WAIT: begin
            // a flushed access still drains the bus but retires quietly
            if (dbus_rsp_vld)
               state_d = (dbus_rsp_err && !kill) ? ST_EXC : ST_DONE;
            else if (tmo_hit)
               state_d = kill ? ST_DONE : ST_EXC;
         end
         ST_DONE: begin
            lsu_done   = 1'b1;
            lsu_wb_vld = !is_store(op_q) && !kill_q;
            state_d    = ST_IDLE;
         end
         ST_EXC: begin
            lsu_done    = 1'b1;
            lsu_exc_vld = 1'b1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign dbus_req_addr  = dbus_req_vld ? {addr_q[31:2], 2'b00} : 32'd0;
   assign dbus_req_we    = dbus_req_vld && is_store(op_q);
   assign dbus_req_be    = dbus_req_vld ? be : 4'b0000;
   assign dbus_req_wdata = dbus_req_vld ? st_lanes : 32'd0;
   assign lsu_wb_addr    = lsu_wb_vld ? rd_q : 5'd0;
   assign lsu_wb_data    = lsu_wb_vld ? ld_data : 32'd0;
   assign lsu_exc_cause  = lsu_exc_vld ? cause_q : 2'd0;
   assign lsu_exc_addr   = lsu_exc_vld ? addr_q : 32'd0;
   assign lsu_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_peak_dpu_lsu_ctrl.sv
// Directed bench for peak_dpu_lsu_ctrl (TMO_W=4).
// Lanes, extension, misalignment, flush, bus error, timeout.
module tb_peak_dpu_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ls_req_vld, ls_req_rdy;
  logic [2:0]  ls_op;
  logic [31:0] ls_addr, ls_wdata;
  logic [4:0]  ls_rd;
  logic        lsu_flush;
  logic        dbus_req_vld, dbus_req_rdy, dbus_req_we;
  logic [31:0] dbus_req_addr, dbus_req_wdata;
  logic [3:0]  dbus_req_be;
  logic        dbus_rsp_vld, dbus_rsp_err;
  logic [31:0] dbus_rsp_rdata;
  logic        lsu_wb_vld, lsu_done, lsu_exc_vld, lsu_busy;
  logic [4:0]  lsu_wb_addr;
  logic [31:0] lsu_wb_data, lsu_exc_addr;
  logic [1:0]  lsu_exc_cause;

  int nchk = 0;
  int nerr = 0;
  int cnt;

  always #5 clk = ~clk;

  peak_dpu_lsu_ctrl #(.TMO_W(4), .TMO_EN(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ls_req_vld     (ls_req_vld),
    .ls_req_rdy     (ls_req_rdy),
    .ls_op          (ls_op),
    .ls_addr        (ls_addr),
    .ls_wdata       (ls_wdata),
    .ls_rd          (ls_rd),
    .lsu_flush      (lsu_flush),
    .dbus_req_vld   (dbus_req_vld),
    .dbus_req_rdy   (dbus_req_rdy),
    .dbus_req_addr  (dbus_req_addr),
    .dbus_req_we    (dbus_req_we),
    .dbus_req_be    (dbus_req_be),
    .dbus_req_wdata (dbus_req_wdata),
    .dbus_rsp_vld   (dbus_rsp_vld),
    .dbus_rsp_rdata (dbus_rsp_rdata),
    .dbus_rsp_err   (dbus_rsp_err),
    .lsu_wb_vld     (lsu_wb_vld),
    .lsu_wb_addr    (lsu_wb_addr),
    .lsu_wb_data    (lsu_wb_data),
    .lsu_done       (lsu_done),
    .lsu_exc_vld    (lsu_exc_vld),
    .lsu_exc_cause  (lsu_exc_cause),
    .lsu_exc_addr   (lsu_exc_addr),
    .lsu_busy       (lsu_busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [4:0] rd);
    ls_req_vld = 1'b1;
    ls_op      = op;
    ls_addr    = a;
    ls_wdata   = d;
    ls_rd      = rd;
    step();
    ls_req_vld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ls_req_vld = 1'b0; ls_op = 3'd0; ls_addr = 32'd0;
    ls_wdata = 32'd0; ls_rd = 5'd0; lsu_flush = 1'b0;
    dbus_req_rdy = 1'b0; dbus_rsp_vld = 1'b0;
    dbus_rsp_rdata = 32'd0; dbus_rsp_err = 1'b0;
    step(); step();
    chk("rst_rdy", ls_req_rdy, 1'b1);
    chk("rst_req_vld", dbus_req_vld, 1'b0);
    chk("rst_be", dbus_req_be, 4'b0000);
    chk("rst_busy", lsu_busy, 1'b0);
    chk("rst_done", lsu_done, 1'b0);
    chk("rst_exc", lsu_exc_vld, 1'b0);
    chk("rst_wb_data", lsu_wb_data, 32'd0);
    #3 rst_n = 1'b1;
    step();

    issue(3'd0, 32'h1003, 32'd0, 5'd5);
    chk("lb_req_vld", dbus_req_vld, 1'b1);
    chk("lb_rdy_busy", ls_req_rdy, 1'b0);
    chk("lb_addr", dbus_req_addr, 32'h1000);
    chk("lb_be", dbus_req_be, 4'b1000);
    chk("lb_we", dbus_req_we, 1'b0);
    dbus_req_rdy = 1'b1;
    step();
    dbus_req_rdy = 1'b0;
    dbus_rsp_vld = 1'b1; dbus_rsp_rdata = 32'h80AA_BBCC;
    chk("lb_wait_vld", dbus_req_vld, 1'b0);
    chk("lb_wait_done", lsu_done, 1'b0);
    step();
    dbus_rsp_vld = 1'b0;
    chk("lb_done", lsu_done, 1'b1);
    chk("lb_wb_vld", lsu_wb_vld, 1'b1);
    chk("lb_wb_data", lsu_wb_data, 32'hFFFF_FF80);
    chk("lb_wb_addr", lsu_wb_addr, 5'd5);
    chk("lb_exc", lsu_exc_vld, 1'b0);
    step();
    chk("lb_idle_done", lsu_done, 1'b0);
    chk("lb_idle_busy", lsu_busy, 1'b0);

    issue(3'd6, 32'h2002, 32'h1234_5678, 5'd0);
    chk("sh_be", dbus_req_be, 4'b1100);
    chk("sh_wdata", dbus_req_wdata, 32'h5678_5678);
    chk("sh_we", dbus_req_we, 1'b1);
    chk("sh_addr", dbus_req_addr, 32'h2000);
    dbus_req_rdy = 1'b1;
    step();
    dbus_req_rdy = 1'b0;
    dbus_rsp_vld = 1'b1; dbus_rsp_rdata = 32'hDEAD_BEEF;
    step();
    dbus_rsp_vld = 1'b0;
    chk("sh_done", lsu_done, 1'b1);
    chk("sh_no_wb", lsu_wb_vld, 1'b0);
    chk("sh_no_exc", lsu_exc_vld, 1'b0);
    step();

    issue(3'd2, 32'h3001, 32'd0, 5'd1);
    chk("lw_mis_no_req", dbus_req_vld, 1'b0);
    chk("lw_mis_done", lsu_done, 1'b1);
    chk("lw_mis_exc", lsu_exc_vld, 1'b1);
    chk("lw_mis_cause", lsu_exc_cause, 2'd0);
    chk("lw_mis_addr", lsu_exc_addr, 32'h3001);
    step();
    chk("lw_mis_idle", lsu_busy, 1'b0);

    issue(3'd7, 32'h4000, 32'hCAFE_F00D, 5'd0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (dbus_req_vld && dbus_req_addr == 32'h4000) cnt++;
      step();
    end
    chk("sw_held_cycles", cnt, 5);
    chk("sw_held_wdata", dbus_req_wdata, 32'hCAFE_F00D);
    lsu_flush = 1'b1;
    step();
    lsu_flush = 1'b0;
    chk("sw_flush_idle", lsu_busy, 1'b0);
    chk("sw_flush_no_done", lsu_done, 1'b0);
    chk("sw_flush_no_req", dbus_req_vld, 1'b0);

    issue(3'd1, 32'h8002, 32'd0, 5'd9);
    dbus_rsp_vld = 1'b1; dbus_rsp_rdata = 32'h1111_1111;
    step();
    dbus_rsp_vld = 1'b0;
    chk("lh_stray_ignored", dbus_req_vld, 1'b1);
    dbus_req_rdy = 1'b1;
    step();
    dbus_req_rdy = 1'b0;
    dbus_rsp_vld = 1'b1; dbus_rsp_rdata = 32'h8001_0000;
    step();
    dbus_rsp_vld = 1'b0;
    chk("lh_wb_data", lsu_wb_data, 32'hFFFF_8001);
    chk("lh_wb_addr", lsu_wb_addr, 5'd9);
    step();

    issue(3'd4, 32'h5002, 32'd0, 5'd3);
    dbus_req_rdy = 1'b1;
    step();
    dbus_req_rdy = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (lsu_done || !lsu_busy) break;
      cnt++;
      step();
    end
    chk("tmo_wait_cycles", cnt, 15);
    chk("tmo_exc", lsu_exc_vld, 1'b1);
    chk("tmo_cause", lsu_exc_cause, 2'd2);
    chk("tmo_addr", lsu_exc_addr, 32'h5002);
    step();

    issue(3'd5, 32'h6001, 32'h0000_00AB, 5'd0);
    chk("sb_be", dbus_req_be, 4'b0010);
    chk("sb_wdata", dbus_req_wdata, 32'hABAB_ABAB);
    dbus_req_rdy = 1'b1;
    step();
    dbus_req_rdy = 1'b0;
    dbus_rsp_vld = 1'b1; dbus_rsp_err = 1'b1;
    step();
    dbus_rsp_vld = 1'b0; dbus_rsp_err = 1'b0;
    chk("sb_err_exc", lsu_exc_vld, 1'b1);
    chk("sb_err_cause", lsu_exc_cause, 2'd3);
    chk("sb_err_addr", lsu_exc_addr, 32'h6001);
    step();

    issue(3'd3, 32'h7002, 32'd0, 5'd4);
    dbus_req_rdy = 1'b1;
    step();
    dbus_req_rdy = 1'b0;
    lsu_flush = 1'b1;
    step();
    lsu_flush = 1'b0;
    dbus_rsp_vld = 1'b1; dbus_rsp_rdata = 32'h00FF_0000;
    step();
    dbus_rsp_vld = 1'b0;
    chk("lbu_fl_done", lsu_done, 1'b1);
    chk("lbu_fl_no_wb", lsu_wb_vld, 1'b0);
    chk("lbu_fl_no_exc", lsu_exc_vld, 1'b0);
    step();

    issue(3'd3, 32'h7002, 32'd0, 5'd4);
    dbus_req_rdy = 1'b1;
    step();
    dbus_req_rdy = 1'b0;
    dbus_rsp_vld = 1'b1; dbus_rsp_rdata = 32'h00FF_0000;
    step();
    dbus_rsp_vld = 1'b0;
    chk("lbu_wb_vld", lsu_wb_vld, 1'b1);
    chk("lbu_wb_data", lsu_wb_data, 32'h0000_00FF);
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
